// File: rtl/riscv_ctrl_pkg.sv
// Shared opcode, state and decode-control definitions for the multi-cycle
// RV32 control sequencer.
package riscv_ctrl_pkg;

   localparam int unsigned OPC_W    = 7;
   localparam int unsigned ALUOP_W  = 2;
   localparam int unsigned RWSEL_W  = 2;

   localparam logic [OPC_W-1:0] R_TYPE = 7'b0110011;
   localparam logic [OPC_W-1:0] I_TYPE = 7'b0010011;
   localparam logic [OPC_W-1:0] U_TYPE = 7'b0110111;
   localparam logic [OPC_W-1:0] LW     = 7'b0000011;
   localparam logic [OPC_W-1:0] SW     = 7'b0100011;
   localparam logic [OPC_W-1:0] BR     = 7'b1100011;
   localparam logic [OPC_W-1:0] JAL    = 7'b1101111;
   localparam logic [OPC_W-1:0] JALR   = 7'b1100111;
   localparam logic [OPC_W-1:0] HALT   = 7'b0000001;

   localparam logic [ALUOP_W-1:0] ALUOP_MEM   = 2'b00;
   localparam logic [ALUOP_W-1:0] ALUOP_BR    = 2'b01;
   localparam logic [ALUOP_W-1:0] ALUOP_ARITH = 2'b10;
   localparam logic [ALUOP_W-1:0] ALUOP_UPPER = 2'b11;

   localparam logic [RWSEL_W-1:0] RW_ALU = 2'b00;
   localparam logic [RWSEL_W-1:0] RW_PC4 = 2'b01;
   localparam logic [RWSEL_W-1:0] RW_IMM = 2'b11;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALTED = 3'd5
   } state_t;

   typedef struct packed {
      logic               alu_src;
      logic               mem_to_reg;
      logic [ALUOP_W-1:0] alu_op;
      logic               branch;
      logic [RWSEL_W-1:0] rw_sel;
      logic               jalr_sel;
   } dec_ctrl_t;

   // Opcodes that execute normally (HALT is handled separately).
   function automatic logic is_known(input logic [OPC_W-1:0] opc);
      logic known;
      case (opc)
         R_TYPE, I_TYPE, U_TYPE, LW, SW, BR, JAL, JALR: known = 1'b1;
         default:                                       known = 1'b0;
      endcase
      return known;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the IR/memory port and the multi-cycle sequencer.
interface multicycle_ctrl_if;
   import riscv_ctrl_pkg::*;

   logic [OPC_W-1:0]   Opcode;
   logic               mem_ready;
   logic               IRWrite;
   logic               PCWrite;
   logic               RegWrite;
   logic               MemRead;
   logic               MemWrite;
   logic               ALUSrc;
   logic               MemtoReg;
   logic [ALUOP_W-1:0] ALUOp;
   logic               Branch;
   logic [RWSEL_W-1:0] RW_selec;
   logic               jalr_selec;
   logic               halted;
   logic               illegal;

   modport master (
      input  Opcode, mem_ready,
      output IRWrite, PCWrite, RegWrite, MemRead, MemWrite,
             ALUSrc, MemtoReg, ALUOp, Branch, RW_selec, jalr_selec,
             halted, illegal
   );

   modport slave (
      output Opcode, mem_ready,
      input  IRWrite, PCWrite, RegWrite, MemRead, MemWrite,
             ALUSrc, MemtoReg, ALUOp, Branch, RW_selec, jalr_selec,
             halted, illegal
   );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational map from the latched opcode to the held datapath controls.
module ctrl_decode
   import riscv_ctrl_pkg::*;
(
   input  logic [OPC_W-1:0] opc,
   output dec_ctrl_t        dec
);

   always_comb begin
      dec        = '0;
      dec.alu_op = ALUOP_MEM;
      dec.rw_sel = RW_ALU;
      case (opc)
         R_TYPE: dec.alu_op = ALUOP_ARITH;
         I_TYPE: begin
            dec.alu_src = 1'b1;
            dec.alu_op  = ALUOP_ARITH;
         end
         U_TYPE: begin
            dec.alu_src = 1'b1;
            dec.alu_op  = ALUOP_UPPER;
            dec.rw_sel  = RW_IMM;
         end
         LW: begin
            dec.alu_src    = 1'b1;
            dec.mem_to_reg = 1'b1;
         end
         SW: dec.alu_src = 1'b1;
         BR: begin
            dec.alu_op = ALUOP_BR;
            dec.branch = 1'b1;
         end
         JAL: begin
            dec.alu_src = 1'b1;
            dec.alu_op  = ALUOP_UPPER;
            dec.branch  = 1'b1;
            dec.rw_sel  = RW_PC4;
         end
         JALR: begin
            dec.alu_src  = 1'b1;
            dec.alu_op   = ALUOP_ARITH;
            dec.branch   = 1'b1;
            dec.rw_sel   = RW_PC4;
            dec.jalr_sel = 1'b1;
         end
         HALT:    dec.alu_op = ALUOP_UPPER;
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving the shared RV32
// datapath strobes and held decode controls.
module multicycle_ctrl
   import riscv_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   multicycle_ctrl_if.master  bus
);

   state_t           state_q, state_d;
   logic [OPC_W-1:0] opc_q, opc_d;
   dec_ctrl_t        dec;
   logic             dec_en;

   logic ir_write, pc_write, reg_write, mem_read, mem_write, illegal_p, halted_p;

   ctrl_decode u_decode (
      .opc (opc_q),
      .dec (dec)
   );

   // Next state and per-state strobes; mem_ready only matters in FETCH/MEM.
   always_comb begin
      state_d   = state_q;
      opc_d     = opc_q;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      illegal_p = 1'b0;
      halted_p  = 1'b0;
      case (state_q)
         FETCH: begin
            mem_read = 1'b1;
            if (bus.mem_ready) begin
               ir_write = 1'b1;
               state_d  = DECODE;
            end
         end
         DECODE: begin
            opc_d = bus.Opcode;
            if (bus.Opcode == HALT) begin
               state_d = HALTED;
            end else if (is_known(bus.Opcode)) begin
               state_d = EXEC;
            end else begin
               illegal_p = 1'b1;
               pc_write  = 1'b1;
               state_d   = FETCH;
            end
         end
         EXEC: begin
            if (opc_q == LW || opc_q == SW) begin
               state_d = MEM;
            end else if (opc_q == BR) begin
               pc_write = 1'b1;
               state_d  = FETCH;
            end else begin
               state_d = WB;
            end
         end
         MEM: begin
            mem_read  = (opc_q == LW);
            mem_write = (opc_q != LW);
            if (bus.mem_ready) begin
               if (opc_q == LW) begin
                  state_d = WB;
               end else begin
                  pc_write = 1'b1;
                  state_d  = FETCH;
               end
            end
         end
         WB: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
            state_d   = FETCH;
         end
         HALTED:  halted_p = 1'b1;
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= FETCH;
         opc_q   <= '0;
      end else begin
         state_q <= state_d;
         opc_q   <= opc_d;
      end
   end

   // Held controls live from EXEC to the end of the instruction; reset
   // blanks every output immediately, without waiting for a clock edge.
   assign dec_en = !reset && (state_q == EXEC || state_q == MEM || state_q == WB);

   assign bus.IRWrite    = ir_write  & ~reset;
   assign bus.PCWrite    = pc_write  & ~reset;
   assign bus.RegWrite   = reg_write & ~reset;
   assign bus.MemRead    = mem_read  & ~reset;
   assign bus.MemWrite   = mem_write & ~reset;
   assign bus.illegal    = illegal_p & ~reset;
   assign bus.halted     = halted_p  & ~reset;

   assign bus.ALUSrc     = dec_en & dec.alu_src;
   assign bus.MemtoReg   = dec_en & dec.mem_to_reg;
   assign bus.ALUOp      = dec_en ? dec.alu_op : ALUOP_W'(0);
   assign bus.Branch     = dec_en & dec.branch;
   assign bus.RW_selec   = dec_en ? dec.rw_sel : RWSEL_W'(0);
   assign bus.jalr_selec = dec_en & dec.jalr_sel;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed and randomized checks of multicycle_ctrl against a phase-list
// model of each instruction's cycle-by-cycle strobe trace.
module tb_multicycle_ctrl;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_HALT = 7'b0000001;

   // Strobe vector bits: {IRWrite, PCWrite, RegWrite, MemRead, MemWrite, illegal, halted}
   localparam logic [6:0] S_IR  = 7'b1000000;
   localparam logic [6:0] S_PC  = 7'b0100000;
   localparam logic [6:0] S_RW  = 7'b0010000;
   localparam logic [6:0] S_MR  = 7'b0001000;
   localparam logic [6:0] S_MW  = 7'b0000100;
   localparam logic [6:0] S_ILL = 7'b0000010;
   localparam logic [6:0] S_HLT = 7'b0000001;

   localparam logic [1:0] MR_LO  = 2'd0;
   localparam logic [1:0] MR_HI  = 2'd1;
   localparam logic [1:0] MR_RND = 2'd2;

   typedef struct packed {
      logic [6:0] strb;
      logic       dv;
      logic [1:0] mr_in;
      logic       dec_ph;
   } cyc_t;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;
   cyc_t tr[$];
   logic [6:0] listed [8];

   multicycle_ctrl_if bus ();

   multicycle_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] strobes();
      return {bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemRead,
              bus.MemWrite, bus.illegal, bus.halted};
   endfunction

   function automatic logic [7:0] decs();
      return {bus.ALUSrc, bus.MemtoReg, bus.ALUOp, bus.Branch, bus.RW_selec, bus.jalr_selec};
   endfunction

   // {ALUSrc, MemtoReg, ALUOp[1:0], Branch, RW_selec[1:0], jalr_selec}
   function automatic logic [7:0] dec_tab(input logic [6:0] opc);
      case (opc)
         OP_R:    return 8'b0_0_10_0_00_0;
         OP_I:    return 8'b1_0_10_0_00_0;
         OP_LUI:  return 8'b1_0_11_0_11_0;
         OP_LW:   return 8'b1_1_00_0_00_0;
         OP_SW:   return 8'b1_0_00_0_00_0;
         OP_BR:   return 8'b0_0_01_1_00_0;
         OP_JAL:  return 8'b1_0_11_1_01_0;
         OP_JALR: return 8'b1_0_10_1_01_1;
         default: return 8'h00;
      endcase
   endfunction

   function automatic bit is_listed(input logic [6:0] opc);
      for (int i = 0; i < 8; i++) if (listed[i] == opc) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit writes_reg(input logic [6:0] opc);
      return opc == OP_R || opc == OP_I || opc == OP_LUI || opc == OP_JAL ||
             opc == OP_JALR || opc == OP_LW;
   endfunction

   function automatic logic [6:0] pick_illegal();
      logic [6:0] v;
      do v = 7'($urandom); while (is_listed(v) || v == OP_HALT);
      return v;
   endfunction

   function void add(input logic [6:0] strb, input logic dv, input logic [1:0] mr_in,
                     input logic dec_ph);
      cyc_t c;
      c.strb   = strb;
      c.dv     = dv;
      c.mr_in  = mr_in;
      c.dec_ph = dec_ph;
      tr.push_back(c);
   endfunction

   // Expected trace as a list of instruction phases.
   task automatic build(input logic [6:0] opc, input int fs, input int ms);
      logic [6:0] ms_strb;
      tr.delete();
      for (int i = 0; i < fs; i++) add(S_MR, 1'b0, MR_LO, 1'b0);
      add(S_MR | S_IR, 1'b0, MR_HI, 1'b0);
      if (opc == OP_HALT) begin
         add(7'b0, 1'b0, MR_RND, 1'b1);
         for (int i = 0; i < 10; i++) add(S_HLT, 1'b0, MR_RND, 1'b0);
         return;
      end
      if (!is_listed(opc)) begin
         add(S_ILL | S_PC, 1'b0, MR_RND, 1'b1);
         return;
      end
      add(7'b0, 1'b0, MR_RND, 1'b1);
      add((opc == OP_BR) ? S_PC : 7'b0, 1'b1, MR_RND, 1'b0);
      if (opc == OP_LW || opc == OP_SW) begin
         ms_strb = (opc == OP_LW) ? S_MR : S_MW;
         for (int i = 0; i < ms; i++) add(ms_strb, 1'b1, MR_LO, 1'b0);
         add(ms_strb | ((opc == OP_SW) ? S_PC : 7'b0), 1'b1, MR_HI, 1'b0);
      end
      if (writes_reg(opc)) add(S_RW | S_PC, 1'b1, MR_RND, 1'b0);
   endtask

   // Drive one instruction; ncyc < 0 runs it to completion.
   task automatic run_instr(input logic [6:0] opc, input int fs, input int ms,
                            input string tag, input int ncyc);
      int   pcw = 0;
      int   rww = 0;
      int   n;
      cyc_t c;
      build(opc, fs, ms);
      n = (ncyc < 0) ? tr.size() : ncyc;
      for (int i = 0; i < n; i++) begin
         c = tr[i];
         bus.Opcode    = c.dec_ph ? opc : 7'($urandom);
         bus.mem_ready = (c.mr_in == MR_RND) ? 1'($urandom) : c.mr_in[0];
         @(negedge clk);
         chk($sformatf("%s.c%0d.strb", tag, i), {1'b0, strobes()}, {1'b0, c.strb});
         chk($sformatf("%s.c%0d.dec", tag, i), decs(), c.dv ? dec_tab(opc) : 8'h00);
         pcw += int'(bus.PCWrite);
         rww += int'(bus.RegWrite);
         @(posedge clk);
         #1;
      end
      if (ncyc < 0 && opc != OP_HALT) begin
         chk($sformatf("%s.pcw_count", tag), 8'(pcw), 8'd1);
         chk($sformatf("%s.rw_count", tag), 8'(rww), writes_reg(opc) ? 8'd1 : 8'd0);
      end
   endtask

   task automatic pulse_reset(input string tag);
      reset = 1'b1;
      #1;
      chk({tag, ".async_strb"}, {1'b0, strobes()}, 8'h00);
      chk({tag, ".async_dec"}, decs(), 8'h00);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk({tag, ".held_strb"}, {1'b0, strobes()}, 8'h00);
      @(posedge clk);
      #1;
      reset         = 1'b0;
      bus.mem_ready = 1'b0;
      @(negedge clk);
      chk({tag, ".fetch_strb"}, {1'b0, strobes()}, {1'b0, S_MR});
      chk({tag, ".fetch_dec"}, decs(), 8'h00);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [6:0] opc;
      int         k;
      listed = '{OP_R, OP_I, OP_LUI, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR};
      reset         = 1'b1;
      bus.Opcode    = OP_R;
      bus.mem_ready = 1'b1;
      @(negedge clk);
      chk("reset.strb", {1'b0, strobes()}, 8'h00);
      chk("reset.dec", decs(), 8'h00);
      @(posedge clk);
      #1;
      reset = 1'b0;

      run_instr(OP_R,    0, 0, "add",     -1);
      run_instr(OP_LW,   0, 2, "lw_stall", -1);
      run_instr(OP_SW,   0, 0, "sw",      -1);
      run_instr(OP_BR,   0, 0, "beq",     -1);
      run_instr(OP_JALR, 0, 0, "jalr",    -1);
      run_instr(OP_LUI,  0, 0, "lui",     -1);
      run_instr(7'b1111111, 0, 0, "ill",  -1);
      run_instr(OP_I,    1, 0, "addi_fs", -1);
      run_instr(OP_JAL,  0, 0, "jal",     -1);

      for (int it = 0; it < 40; it++) begin
         k   = $urandom_range(0, 8);
         opc = (k < 8) ? listed[k] : pick_illegal();
         run_instr(opc, $urandom_range(0, 2), $urandom_range(0, 3),
                   $sformatf("rnd%0d_%b", it, opc), -1);
      end

      // Stop a LW three cycles into a stalled MEM wait.
      run_instr(OP_LW, 0, 5, "lw_cut", 5);
      bus.mem_ready = 1'b0;
      #2;
      chk("lw_cut.mem_wait", {1'b0, strobes()}, {1'b0, S_MR});
      pulse_reset("rst_mem");
      run_instr(OP_R, 0, 0, "add_after_rst", -1);

      run_instr(OP_HALT, 1, 0, "halt", -1);
      pulse_reset("rst_halt");
      run_instr(OP_SW, 0, 1, "sw_after_halt", -1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the RV32 core's shared datapath. It latches the instruction opcode and steps one instruction through FETCH/DECODE/EXEC/MEM/WB states. It emits the per-state write strobes (PC, IR, register file, data memory) plus the held decode controls for the ALU, write-back mux and branch logic. It sits between the instruction register and the datapath, and replaces the single-cycle control path when the core runs with one unified memory port.

## Interface
- No parameters.
- clk  in  1  core clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; forces state FETCH and all outputs low
- Opcode  in  7  instruction bits [6:0] from the IR; read only in DECODE
- mem_ready  in  1  memory port done; sampled in FETCH and MEM
- IRWrite  out  1  load IR
- PCWrite  out  1  update PC; the datapath picks PC+4 or target using Branch
- RegWrite  out  1  register file write strobe
- MemRead  out  1  data read request
- MemWrite  out  1  data write request
- ALUSrc  out  1  0 = rs2, 1 = immediate
- MemtoReg  out  1  1 = write-back from memory
- ALUOp  out  2  00 LW/SW, 01 branch, 10 R/I/JALR, 11 LUI/JAL/HALT
- Branch  out  1  branch/jump class
- RW_selec  out  2  00 ALU/mem, 01 PC+4 (JAL/JALR), 11 immediate (LUI)
- jalr_selec  out  1  target = rs1+imm
- halted  out  1  core stopped
- illegal  out  1  one-cycle pulse on an unknown opcode

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALTED.
- FETCH:
  - MemRead=1 until mem_ready.
  - When mem_ready=1: IRWrite=1 for that cycle, then go to DECODE.
- DECODE:
  - Capture Opcode into opc_q.
  - HALT (0000001) goes to HALTED.
  - Any other unlisted opcode pulses illegal, asserts PCWrite, and returns to FETCH.
  - All listed opcodes go to EXEC.
- EXEC next state:
  - R, I (0010011), LUI (0110111), JAL, JALR go to WB.
  - LW (0000011) and SW (0100011) go to MEM.
  - BR (1100011) asserts PCWrite and goes to FETCH.
- MEM:
  - LW holds MemRead=1; SW holds MemWrite=1.
  - Stay in MEM while mem_ready=0.
  - On mem_ready=1: LW goes to WB; SW asserts PCWrite and goes to FETCH.
- WB: RegWrite=1 and PCWrite=1 for one cycle, then FETCH.
- HALTED:
  - All strobes 0, halted=1.
  - Exits only on reset.
- Decode controls (ALUSrc, MemtoReg, ALUOp, Branch, RW_selec, jalr_selec):
  - Combinational from opc_q.
  - Valid from EXEC through the end of the instruction.
  - Forced to 0 in FETCH and HALTED.
- Each instruction produces exactly one PCWrite pulse and at most one RegWrite pulse.

## Timing
- Reset value: state FETCH, opc_q=0, and every output 0.
  - Because state is FETCH, MemRead rises in the first cycle after reset deasserts.
- Instruction latency with mem_ready tied high:
  - R/I/LUI/JAL/JALR: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BR: 3 cycles.
  - Illegal opcode: 2 cycles.
- Each cycle with mem_ready=0 in FETCH or MEM adds exactly one cycle.
- The datapath captures strobes on the rising edge that ends the cycle in which they are high.
- Reset asserted in any state, including mid-wait in MEM:
  - Outputs drop to 0 asynchronously.
  - No partial RegWrite or PCWrite is issued.
- mem_ready in DECODE, EXEC or WB is ignored.

## Structure
- Package riscv_ctrl_pkg holds:
  - opcode localparams: R_TYPE, I_TYPE, U_TYPE, LW, SW, BR, JAL, JALR, HALT
  - state_t enum
  - ALUOp and RW_selec encodings
- Sub-module ctrl_decode: purely combinational, maps opc_q to the held decode controls.
  - The FSM gates its outputs with the current state.

## Test plan
- ADD 0110011, mem_ready=1:
  - IRWrite in cycle 0; ALUOp=10 and ALUSrc=0 in cycle 2.
  - RegWrite and PCWrite in cycle 3; FETCH again in cycle 4.
- LW with mem_ready low for 2 MEM cycles:
  - MemRead held 3 cycles.
  - Then MemtoReg=1 and RegWrite=1 in WB; total 7 cycles.
- SW then BEQ back-to-back:
  - SW: MemWrite=1 for 1 cycle, RegWrite never 1.
  - BEQ: Branch=1, ALUOp=01, PCWrite in EXEC.
- JALR 1100111: RW_selec=01, jalr_selec=1, ALUSrc=1, Branch=1, and RegWrite in WB.
  - LUI follows: RW_selec=11, ALUOp=11.
- Opcode 1111111: illegal=1 and PCWrite=1 in DECODE; next instruction fetched 2 cycles after the first IRWrite.
- HALT:
  - halted=1 from DECODE+1 with all strobes 0 for 10 cycles.
  - Reset asserted during a stalled LW MEM state: outputs 0 immediately, FETCH after release.
